// File: rtl/data_route_mode_ctrl_if.sv
// Stream handshake taps (f and h) and the valid-gating enables that
// data_route_mode_ctrl returns for them.
interface data_route_mode_ctrl_if;
   logic f_tvalid;
   logic f_tready;
   logic f_tlast;
   logic h_tvalid;
   logic h_tready;
   logic h_tlast;
   logic f_en;
   logic h_en;

   modport master (
      output f_tvalid, f_tready, f_tlast,
      output h_tvalid, h_tready, h_tlast,
      input  f_en, h_en
   );

   modport slave (
      input  f_tvalid, f_tready, f_tlast,
      input  h_tvalid, h_tready, h_tlast,
      output f_en, h_en
   );
endinterface

// File: rtl/data_route_mode_ctrl.sv
// Job sequencer: switches interconnect mode, gates f/h streams, counts f packets.
// Optional watchdog built in when DATA_ROUTE_MODE_CTRL_TIMEOUT_EN is defined.
module data_route_mode_ctrl #(
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned SWITCH_GAP     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cfg_mode,
   input  logic [CNT_W-1:0]     cfg_pkt_num,
   data_route_mode_ctrl_if.slave strm,
   output logic                 mode,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CNT_W-1:0]     pkt_cnt
);

   localparam int unsigned GAP   = (SWITCH_GAP < 1) ? 1 : SWITCH_GAP;
   localparam int unsigned GAP_W = $clog2(GAP + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] pkt_num;
   logic [GAP_W-1:0] gap_cnt;
   logic             h_in_pkt;
   logic             f_en_q;
   logic             h_en_q;

   logic             f_hs;
   logic             f_last_hs;
   logic             h_hs;
   logic             h_in_pkt_nxt;
   logic             last_pkt;
   logic             drain_exit;
   logic             wd_fire;

   assign strm.f_en = f_en_q;
   assign strm.h_en = h_en_q;

   // Only handshakes the controller has enabled are counted or tracked.
   always_comb begin
      f_hs         = f_en_q & strm.f_tvalid & strm.f_tready;
      f_last_hs    = f_hs & strm.f_tlast;
      h_hs         = h_en_q & strm.h_tvalid & strm.h_tready;
      h_in_pkt_nxt = h_hs ? ~strm.h_tlast : h_in_pkt;
      last_pkt     = ((pkt_cnt + CNT_W'(1)) == pkt_num);
      drain_exit   = (state == DRAIN) && !h_in_pkt_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mode     <= 1'b0;
         f_en_q   <= 1'b0;
         h_en_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pkt_cnt  <= '0;
         pkt_num  <= '0;
         gap_cnt  <= '0;
         h_in_pkt <= 1'b0;
      end else begin
         h_in_pkt <= h_in_pkt_nxt;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pkt_num <= cfg_pkt_num;
                  mode    <= cfg_mode;
                  pkt_cnt <= '0;
                  gap_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (gap_cnt == GAP_W'(GAP - 1)) begin
                  if (pkt_num == '0) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     f_en_q <= 1'b1;
                     h_en_q <= 1'b1;
                     state  <= RUN;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            RUN: begin
               if (f_last_hs) begin
                  pkt_cnt <= pkt_cnt + CNT_W'(1);
               end
               // The final completion drops f_en at once so no extra f beat slips through.
               if (f_last_hs && last_pkt) begin
                  f_en_q <= 1'b0;
                  state  <= DRAIN;
               end else if (wd_fire) begin
                  f_en_q <= 1'b0;
                  h_en_q <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DRAIN: begin
               if (drain_exit) begin
                  h_en_q <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (wd_fire) begin
                  h_en_q <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DATA_ROUTE_MODE_CTRL_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_wait;

   // A normal drain exit wins over a coincident watchdog expiry.
   always_comb begin
      wd_wait = (state == RUN) || (state == DRAIN);
      wd_fire = wd_wait && !f_hs && !h_hs && !drain_exit &&
                (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            err <= 1'b0;
         end else if (wd_fire) begin
            err <= 1'b1;
         end
         if (wd_wait && !f_hs && !h_hs && !wd_fire) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end else begin
            wd_cnt <= '0;
         end
      end
   end
`else
   // TIMEOUT_CYCLES only matters with the watchdog built in.
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign wd_fire        = 1'b0;
   assign err            = 1'b0;
`endif

endmodule
